mult_share_arb: RTL and testbench

MULT_SHARE_ARB -- requirements
Module: mult_share_arb

---
 rtl/mult_share_arb.sv | 164 ++++++++++++++++
 tb/tb_mult_share_arb.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_share_arb.sv
// mult_share_arb: round-robin share of one external 16x16 signed multiplier
// among N_CH demodulator channels. Operands arrive in offset binary and are
// converted to two's complement on acceptance. A tag pipeline keeps the
// channel index aligned with the multiplier latency. Each completed product
// is returned as a Q15 response.
module mult_share_arb #(
  parameter int unsigned N_CH     = 4,
  parameter int unsigned MULT_LAT = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_CH-1:0]      ch_en,
  input  logic [N_CH-1:0]      req_valid,
  output logic [N_CH-1:0]      req_ready,
  input  logic [N_CH*16-1:0]   req_sig,
  input  logic [N_CH*16-1:0]   req_car,
  output logic [15:0]          mul_a,
  output logic [15:0]          mul_b,
  input  logic [31:0]          mul_res,
  output logic                 rsp_valid,
  output logic [2:0]           rsp_ch,
  output logic [15:0]          rsp_data,
  output logic                 busy
);

  localparam int unsigned DW    = 16;
  localparam int unsigned CH_W  = 3;
  localparam int unsigned MAX_CH = 8;
  localparam int unsigned N_TAG = MULT_LAT + 1;

  // Arbitration state and combinational grant
  logic [CH_W-1:0]            last_grant_q, last_grant_d;
  logic [MAX_CH-1:0]          cand_c;
  logic                       grant_any_c;
  logic [CH_W-1:0]            grant_idx_c;
  logic [MAX_CH-1:0]          grant_vec_c;
  logic [DW-1:0]              sig_sel_c;
  logic [DW-1:0]              car_sel_c;

  // Operand registers
  logic [DW-1:0]              mul_a_q, mul_a_d;
  logic [DW-1:0]              mul_b_q, mul_b_d;

  // Tag pipeline aligned with the multiplier result
  logic [N_TAG-1:0]           tag_vld_q, tag_vld_d;
  logic [N_TAG-1:0][CH_W-1:0] tag_ch_q,  tag_ch_d;

  // Response registers
  logic                       rsp_valid_q, rsp_valid_d;
  logic [CH_W-1:0]            rsp_ch_q,    rsp_ch_d;
  logic [DW-1:0]              rsp_data_q,  rsp_data_d;
  logic                       busy_q,      busy_d;

  // The low product bits fall below Q15 resolution and are dropped
  logic                       unused_res_c;
  assign unused_res_c = ^mul_res[14:0];

  // Round-robin search starting one past the last granted channel
  always_comb begin
    cand_c      = MAX_CH'(req_valid & ch_en);
    grant_any_c = 1'b0;
    grant_idx_c = '0;
    for (int unsigned k = 1; k <= N_CH; k++) begin
      logic [CH_W-1:0] idx;
      idx = CH_W'((32'(last_grant_q) + k) % N_CH);
      if (!grant_any_c && cand_c[idx]) begin
        grant_any_c = 1'b1;
        grant_idx_c = idx;
      end
    end
    // No grant may be issued while reset is asserted
    if (!rst) begin
      grant_any_c = 1'b0;
      grant_idx_c = '0;
    end
    grant_vec_c = grant_any_c ? (MAX_CH'(1) << grant_idx_c) : '0;
  end

  assign req_ready = N_CH'(grant_vec_c);

  // Select the granted channel's operand pair
  always_comb begin
    sig_sel_c = '0;
    car_sel_c = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (grant_vec_c[i]) begin
        sig_sel_c = req_sig[i*DW +: DW];
        car_sel_c = req_car[i*DW +: DW];
      end
    end
  end

  // Next-state: arbiter pointer, operands, tag shift, response stage
  always_comb begin
    last_grant_d = last_grant_q;
    mul_a_d      = mul_a_q;
    mul_b_d      = mul_b_q;
    tag_vld_d    = '0;
    tag_ch_d     = '0;
    rsp_valid_d  = 1'b0;
    rsp_ch_d     = rsp_ch_q;
    rsp_data_d   = rsp_data_q;

    if (grant_any_c) begin
      last_grant_d = grant_idx_c;
      // Offset binary to two's complement: flip the MSB
      mul_a_d      = {~sig_sel_c[DW-1], sig_sel_c[DW-2:0]};
      mul_b_d      = {~car_sel_c[DW-1], car_sel_c[DW-2:0]};
    end

    tag_vld_d[0] = grant_any_c;
    tag_ch_d[0]  = grant_idx_c;
    for (int unsigned i = 1; i < N_TAG; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_ch_d[i]  = tag_ch_q[i-1];
    end

    // Oldest tag lines up with mul_res; capture Q15 with saturation
    rsp_valid_d = tag_vld_q[N_TAG-1];
    if (tag_vld_q[N_TAG-1]) begin
      rsp_ch_d = tag_ch_q[N_TAG-1];
      if (mul_res[31:30] == 2'b01) begin
        rsp_data_d = 16'h7FFF;
      end else begin
        rsp_data_d = mul_res[30:15];
      end
    end

    busy_d = (|tag_vld_d) | rsp_valid_d;
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_q <= CH_W'(N_CH - 1);
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      tag_vld_q    <= '0;
      tag_ch_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_ch_q     <= '0;
      rsp_data_q   <= '0;
      busy_q       <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      tag_vld_q    <= tag_vld_d;
      tag_ch_q     <= tag_ch_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_ch_q     <= rsp_ch_d;
      rsp_data_q   <= rsp_data_d;
      busy_q       <= busy_d;
    end
  end

  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_ch    = rsp_ch_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mult_share_arb.sv
// tb_mult_share_arb: two instances (multiplier latency 0 and 3) share one
// stimulus stream. The bench provides the external multiplier and checks the
// DUTs against a transaction-level model: a round-robin pick plus a queue of
// expected responses, each with its due edge.
module tb_mult_share_arb;

  localparam int unsigned N_CH = 4;

  typedef struct {
    int          due;
    logic [2:0]  ch;
    logic [15:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N_CH-1:0]    ch_en, req_valid;
  logic [N_CH*16-1:0] req_sig, req_car;

  logic [N_CH-1:0] rdy0, rdy3;
  logic [15:0]     a0, b0, a3, b3;
  logic [31:0]     res0, res3, p1, p2, p3;
  logic            v0, v3, busy0, busy3;
  logic [2:0]      c0, c3;
  logic [15:0]     d0, d3;

  mult_share_arb #(.N_CH(N_CH), .MULT_LAT(0)) u_dut0 (
    .clk(clk), .rst(rst_n), .ch_en(ch_en), .req_valid(req_valid),
    .req_ready(rdy0), .req_sig(req_sig), .req_car(req_car),
    .mul_a(a0), .mul_b(b0), .mul_res(res0), .rsp_valid(v0),
    .rsp_ch(c0), .rsp_data(d0), .busy(busy0)
  );

  mult_share_arb #(.N_CH(N_CH), .MULT_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst_n), .ch_en(ch_en), .req_valid(req_valid),
    .req_ready(rdy3), .req_sig(req_sig), .req_car(req_car),
    .mul_a(a3), .mul_b(b3), .mul_res(res3), .rsp_valid(v3),
    .rsp_ch(c3), .rsp_data(d3), .busy(busy3)
  );

  // External multipliers: combinational and three-stage pipelined
  assign res0 = $signed({{16{a0[15]}}, a0}) * $signed({{16{b0[15]}}, b0});
  always @(posedge clk) begin
    p1 <= $signed({{16{a3[15]}}, a3}) * $signed({{16{b3[15]}}, b3});
    p2 <= p1;
    p3 <= p2;
  end
  assign res3 = p3;

  int          total = 0;
  int          bad   = 0;
  int          ecnt  = 0;
  int          last_g;
  logic [15:0] exp_a, exp_b;
  exp_t        q0[$];
  exp_t        q3[$];

  // Count one comparison; report a mismatch
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Next enabled+valid channel after the last grant, or -1
  function automatic int pick_grant();
    for (int k = 1; k <= int'(N_CH); k++) begin
      int i;
      i = (last_g + k) % int'(N_CH);
      if (ch_en[i] && req_valid[i]) return i;
    end
    return -1;
  endfunction

  // Product of two offset-binary samples as truncated, saturated Q15
  function automatic logic [15:0] q15_prod(input logic [15:0] s, input logic [15:0] c);
    longint sv, cv, p;
    sv = longint'(s) - 64'sd32768;
    cv = longint'(c) - 64'sd32768;
    p  = sv * cv;
    if (p == 64'sd1073741824) return 16'h7FFF;
    return 16'(p >>> 15);
  endfunction

  function automatic logic [15:0] rand16();
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h8000;
      3: return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic rand_data();
    for (int i = 0; i < int'(N_CH); i++) begin
      req_sig[i*16 +: 16] = rand16();
      req_car[i*16 +: 16] = rand16();
    end
  endtask

  // One clock: check grant before the edge, update model, check outputs after
  task automatic cycle();
    int   g;
    exp_t e;
    logic bexp;
    #1;
    g = rst_n ? pick_grant() : -1;
    chk("ready0", 32'(rdy0), (g < 0) ? 32'd0 : (32'd1 << g));
    chk("ready3", 32'(rdy3), (g < 0) ? 32'd0 : (32'd1 << g));
    @(posedge clk);
    ecnt++;
    if (!rst_n) begin
      q0.delete();
      q3.delete();
      last_g = int'(N_CH) - 1;
      exp_a  = '0;
      exp_b  = '0;
    end else if (g >= 0) begin
      last_g = g;
      exp_a  = req_sig[g*16 +: 16] ^ 16'h8000;
      exp_b  = req_car[g*16 +: 16] ^ 16'h8000;
      e.ch   = 3'(g);
      e.data = q15_prod(req_sig[g*16 +: 16], req_car[g*16 +: 16]);
      e.due  = ecnt + 1;
      q0.push_back(e);
      e.due  = ecnt + 4;
      q3.push_back(e);
    end
    #1;
    chk("mula0", 32'(a0), 32'(exp_a));
    chk("mulb0", 32'(b0), 32'(exp_b));
    chk("mula3", 32'(a3), 32'(exp_a));
    chk("mulb3", 32'(b3), 32'(exp_b));
    if (!rst_n) begin
      chk("rstch0", 32'(c0), 32'd0);
      chk("rstdat0", 32'(d0), 32'd0);
      chk("rstch3", 32'(c3), 32'd0);
      chk("rstdat3", 32'(d3), 32'd0);
    end
    bexp = (q0.size() != 0);
    chk("busy0", 32'(busy0), 32'(bexp));
    if (q0.size() != 0 && q0[0].due == ecnt) begin
      chk("vld0", 32'(v0), 32'd1);
      chk("ch0", 32'(c0), 32'(q0[0].ch));
      chk("dat0", 32'(d0), 32'(q0[0].data));
      void'(q0.pop_front());
    end else begin
      chk("vld0", 32'(v0), 32'd0);
    end
    bexp = (q3.size() != 0);
    chk("busy3", 32'(busy3), 32'(bexp));
    if (q3.size() != 0 && q3[0].due == ecnt) begin
      chk("vld3", 32'(v3), 32'd1);
      chk("ch3", 32'(c3), 32'(q3[0].ch));
      chk("dat3", 32'(d3), 32'(q3[0].data));
      void'(q3.pop_front());
    end else begin
      chk("vld3", 32'(v3), 32'd0);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    req_valid = '0;
    repeat (n) cycle();
  endtask

  initial begin
    rst_n     = 1'b0;
    ch_en     = '1;
    req_valid = '0;
    req_sig   = '0;
    req_car   = '0;
    last_g    = int'(N_CH) - 1;
    exp_a     = '0;
    exp_b     = '0;
    @(negedge clk);
    repeat (2) cycle();
    rst_n = 1'b1;

    // Fairness from reset: all channels valid continuously
    req_valid = '1;
    repeat (8) begin rand_data(); cycle(); end
    idle(6);

    // Single channel 2: 0xC000 x 0xC000 -> 0x2000
    req_valid = 4'b0100;
    req_sig[47:32] = 16'hC000;
    req_car[47:32] = 16'hC000;
    cycle();
    idle(6);

    // Saturation corner, then 0xFFFF x 0x0000 -> 0x8001
    req_valid = 4'b0001;
    req_sig[15:0] = 16'h0000;
    req_car[15:0] = 16'h0000;
    cycle();
    req_sig[15:0] = 16'hFFFF;
    cycle();
    idle(6);

    // Masking: only channels 1 and 3 enabled
    ch_en     = 4'b1010;
    req_valid = '1;
    repeat (6) begin rand_data(); cycle(); end
    ch_en = '1;
    idle(6);

    // Burst of five back-to-back acceptances, then drain
    req_valid = '1;
    repeat (5) begin rand_data(); cycle(); end
    idle(8);

    // Reset pulse with products in flight
    req_valid = '1;
    repeat (3) begin rand_data(); cycle(); end
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    repeat (3) begin rand_data(); cycle(); end
    idle(8);

    // Randomized enables, requests and operands
    repeat (3000) begin
      ch_en     = N_CH'($urandom);
      req_valid = N_CH'($urandom);
      rand_data();
      cycle();
    end
    idle(8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
